alu_pipe_param: RTL and testbench
=================================

Name: alu_pipe_param

Overview:
- Parametrised, registered-output ALU for the datapath. Generalises the existing 32-bit combinational ALU in width and op set.
- Adds signed compare, shifts, a multi-cycle unsigned multiply, carry/illegal flags and valid/ready handshakes on both sides.
- Sits between operand issue logic and writeback. Holds its result until the consumer accepts it.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept a new operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  operation select
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB) or product truncation (MUL)
- carry  out  1  carry-out (ADD) or borrow (SUB)
- illegal  out  1  unsupported op code

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, result=0, all flags 0, mul counter 0.
  - in_ready is 0 while rst_n=0.
  - Reset mid-MUL aborts the operation; no result is produced.
- Op map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a.
  - 6 EQ, 7 LTU, 8 GTU, 9 LTS (signed). Compare results are the value 1 or 0, not all-ones.
  - 10 SLL, 11 SRL, 12 SRA, with shift amount b[SHW-1:0].
  - 13 MUL: unsigned, low WIDTH bits kept.
  - 14/15: result 0, illegal=1.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept when in_valid && in_ready. a, b and op are sampled only on accept.
- Single-cycle ops (all except MUL):
  - On accept, result and flags are registered at the next edge and out_valid=1. Latency is 1 cycle.
- MUL FSM, states IDLE -> BUSY -> IDLE:
  - On accept: latch a, b; clear the 2*WIDTH accumulator; counter=0; go to BUSY. in_ready=0.
  - BUSY: one shift-add step per cycle for WIDTH cycles.
  - On the last step (counter==WIDTH-1): register result = low half, overflow = (high half != 0), carry=0; set out_valid; return to IDLE.
  - Latency is WIDTH cycles from accept to out_valid.
- Output hold:
  - While out_valid && !out_ready, result and flags are frozen and no new op is accepted.
  - out_valid && out_ready with a simultaneous accept: the new single-cycle result replaces the old one at the same edge and out_valid stays 1.
  - out_valid && out_ready with a simultaneous MUL accept: out_valid drops to 0 for the BUSY period.
  - out_ready without a new accept: out_valid drops to 0 next cycle.
- Flags:
  - zero = (result==0) for every op, including illegal (illegal ops therefore report zero=1).
  - ADD: overflow = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]); carry = bit W of the (W+1)-bit sum.
  - SUB: overflow = (a[W-1]!=b[W-1]) && (r[W-1]!=a[W-1]); carry = borrow = (a <u b).
  - All other single-cycle ops: overflow=0, carry=0.
- Arithmetic wraps modulo 2^WIDTH.
- SRA replicates a[WIDTH-1]. A shift amount of 0 returns a unchanged.

Test Plan:
- WIDTH=32. ADD a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle result=0x80000000, overflow=1, carry=0, zero=0.
- ADD a=0xFFFFFFFF, b=1 -> result=0, zero=1, carry=1, overflow=0. SUB a=1, b=2 -> result=0xFFFFFFFF, carry=1.
- LTS a=0xFFFFFFFF, b=1 -> result=1. LTU with the same operands -> result=0. SRA a=0x80000000, b=4 -> result=0xF8000000.
- MUL a=0x00010000, b=0x00010000 -> in_ready=0 for 32 cycles, then result=0, overflow=1, zero=1. MUL 3*5 -> result=15 after 32 cycles.
- Back-pressure: out_ready=0 after an ADD completes; drive new ops -> in_ready=0, result frozen. Raise out_ready with in_valid=1 -> new result next cycle, out_valid continuous.
- Assert rst_n=0 at cycle 10 of a MUL -> out_valid=0, result=0 immediately. After release, in_ready=1 and a following ADD completes normally. op=15 -> result=0, illegal=1.

Source files
------------

// File: rtl/alu_pipe_param.sv
// Parametrised registered-output ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete in one cycle; MUL runs a WIDTH-step shift-add sequence.
module alu_pipe_param #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
  output logic             illegal
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_EQ  = 4'd6,  OP_LTU = 4'd7;
  localparam logic [3:0] OP_GTU = 4'd8,  OP_LTS = 4'd9,  OP_SLL = 4'd10, OP_SRL = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12, OP_MUL = 4'd13;

  state_t                   state;
  logic                     accept;
  logic [WIDTH:0]           sum;
  logic [WIDTH:0]           diff;
  logic signed [WIDTH-1:0]  sa;
  logic signed [WIDTH-1:0]  sb;
  logic [SHW-1:0]           shamt;
  logic [WIDTH-1:0]         res_c;
  logic                     ovf_c;
  logic                     cy_c;
  logic                     ill_c;

  logic [2*WIDTH-1:0]       mcand_p1;
  logic [WIDTH-1:0]         mplier_p1;
  logic [2*WIDTH-1:0]       acc_p1;
  logic [2*WIDTH-1:0]       acc_nxt;
  logic [SHW-1:0]           cnt_p1;

  assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign sa    = a;
  assign sb    = b;
  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  // bit WIDTH of the extended difference is the borrow, i.e. a <u b
  assign diff  = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    cy_c  = 1'b0;
    ill_c = 1'b0;
    case (op)
      OP_ADD: begin
        res_c = sum[WIDTH-1:0];
        ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        cy_c  = sum[WIDTH];
      end
      OP_SUB: begin
        res_c = diff[WIDTH-1:0];
        ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        cy_c  = diff[WIDTH];
      end
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_XOR: res_c = a ^ b;
      OP_NOT: res_c = ~a;
      OP_EQ:  res_c = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_LTU: res_c = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_GTU: res_c = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_LTS: res_c = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLL: res_c = a << shamt;
      OP_SRL: res_c = a >> shamt;
      OP_SRA: res_c = sa >>> shamt;
      OP_MUL: res_c = '0;
      default: ill_c = 1'b1;
    endcase
  end

  assign acc_nxt = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);

  // Stage p1: multiply operands and accumulator, loaded on accept
  always_ff @(posedge clk) begin
    if (accept && (op == OP_MUL)) begin
      mcand_p1  <= {{WIDTH{1'b0}}, a};
      mplier_p1 <= b;
      acc_p1    <= '0;
    end else if (state == BUSY) begin
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
      acc_p1    <= acc_nxt;
    end
  end

  // Output stage: control FSM and the held result/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      illegal   <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state     <= BUSY;
              cnt_p1    <= '0;
              out_valid <= 1'b0;
            end else begin
              result    <= res_c;
              zero      <= (res_c == '0);
              overflow  <= ovf_c;
              carry     <= cy_c;
              illegal   <= ill_c;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          cnt_p1 <= cnt_p1 + 1'b1;
          if (cnt_p1 == SHW'(WIDTH-1)) begin
            result    <= acc_nxt[WIDTH-1:0];
            zero      <= (acc_nxt[WIDTH-1:0] == '0);
            overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
            carry     <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboard bench for alu_pipe_param at WIDTH=32: stimulus pushes expected
// {result, zero, overflow, carry, illegal}; a monitor pops on each handshake.
module tb_alu_pipe_param;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         carry;
  logic         illegal;

  int errors = 0;
  int checks = 0;
  logic [W+3:0] exp_q[$];

  alu_pipe_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .carry(carry),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [W+3:0] pack(input logic [W-1:0] r, input logic z,
                                        input logic o, input logic c, input logic i);
    return {r, z, o, c, i};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare whenever a result is handed over
  initial begin
    logic [W+3:0] got;
    logic [W+3:0] req;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        got = {result, zero, overflow, carry, illegal};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h with no expected entry", got);
        end else begin
          req = exp_q.pop_front();
          if (got !== req) begin
            errors++;
            $display("FAIL result_flags: got %h expected %h", got, req);
          end
        end
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W+3:0] e, input bit push);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    if (push) exp_q.push_back(e);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: op %0d never accepted", o);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] held;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    op = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({zero, overflow, carry, illegal}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(4'd0,  32'h7FFF_FFFF, 32'h1,         pack(32'h8000_0000, 0, 1, 0, 0), 1);
    send(4'd0,  32'hFFFF_FFFF, 32'h1,         pack(32'h0,         1, 0, 1, 0), 1);
    send(4'd1,  32'h1,         32'h2,         pack(32'hFFFF_FFFF, 0, 0, 1, 0), 1);
    send(4'd1,  32'h8000_0000, 32'h1,         pack(32'h7FFF_FFFF, 0, 1, 0, 0), 1);
    send(4'd9,  32'hFFFF_FFFF, 32'h1,         pack(32'h1,         0, 0, 0, 0), 1);
    send(4'd7,  32'hFFFF_FFFF, 32'h1,         pack(32'h0,         1, 0, 0, 0), 1);
    send(4'd8,  32'h1,         32'hFFFF_FFFF, pack(32'h0,         1, 0, 0, 0), 1);
    send(4'd6,  32'h5,         32'h5,         pack(32'h1,         0, 0, 0, 0), 1);
    send(4'd12, 32'h8000_0000, 32'h4,         pack(32'hF800_0000, 0, 0, 0, 0), 1);
    send(4'd12, 32'h8000_0000, 32'h0,         pack(32'h8000_0000, 0, 0, 0, 0), 1);
    send(4'd11, 32'h8000_0000, 32'd31,        pack(32'h1,         0, 0, 0, 0), 1);
    send(4'd10, 32'h1,         32'd35,        pack(32'h8,         0, 0, 0, 0), 1);
    send(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, pack(32'hF000_F000, 0, 0, 0, 0), 1);
    send(4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, pack(32'h0FF0_0FF0, 0, 0, 0, 0), 1);
    send(4'd3,  32'h0,         32'h0,         pack(32'h0,         1, 0, 0, 0), 1);
    send(4'd5,  32'h0,         32'h1234,      pack(32'hFFFF_FFFF, 0, 0, 0, 0), 1);

    // MUL with truncation, then 3*5; both must take exactly W cycles
    send(4'd13, 32'h0001_0000, 32'h0001_0000, pack(32'h0, 1, 1, 0, 0), 1);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) begin
        errors++;
        checks++;
        $display("FAIL mul_in_ready: got 1 expected 0 at busy cycle %0d", lat);
      end
      lat++;
    end
    check("mul_latency", 64'(lat), 64'(W));
    @(posedge clk);
    #1;
    send(4'd13, 32'd3, 32'd5, pack(32'd15, 0, 0, 0, 0), 1);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check("mul_latency_3x5", 64'(lat), 64'(W));
    @(posedge clk);
    #1;

    // Back-pressure: hold the result, refuse new work, then hand over back to back
    out_ready = 1'b0;
    send(4'd0, 32'd2, 32'd3, pack(32'd5, 0, 0, 0, 0), 1);
    held = result;
    in_valid = 1'b1;
    op = 4'd0;
    a = 32'd10;
    b = 32'd20;
    exp_q.push_back(pack(32'd30, 0, 0, 0, 0));
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result_held", 64'(result), 64'(held));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_out_valid_continuous", 64'(out_valid), 64'd1);
    check("bp_new_result", 64'(result), 64'd30);
    @(posedge clk);
    #1;

    // Reset during a MUL: aborted, nothing produced
    send(4'd13, 32'd7, 32'd9, '0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mul_out_valid", 64'(out_valid), 64'd0);
    check("rst_mul_result", 64'(result), 64'd0);
    check("rst_mul_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    check("post_rst_no_output", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    send(4'd0,  32'd4, 32'd4, pack(32'd8, 0, 0, 0, 0), 1);
    send(4'd15, 32'd5, 32'd6, pack(32'h0, 1, 0, 0, 1), 1);
    send(4'd14, 32'd1, 32'd1, pack(32'h0, 1, 0, 0, 1), 1);

    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
